// File: rtl/addsub_entry_ctrl.sv
// addsub_entry_ctrl: operand entry and add/subtract front end.
// Four raw buttons are synchronised, debounced and edge-detected into
// one-cycle action pulses. A small FSM loads two signed 8-bit operands,
// toggles add/subtract and computes a 9-bit signed result. Registered
// hex value (x) and per-digit minus flags (neg) feed the display driver.
module addsub_entry_ctrl #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  SW,
  input  logic        BTN_A,
  input  logic        BTN_B,
  input  logic        BTN_OP,
  input  logic        BTN_EQ,
  output logic [15:0] x,
  output logic [3:0]  neg,
  output logic        OP_SUB
);

  // Last counter value before a level change is accepted.
  localparam logic [19:0] DEB_LAST = DEB_CYCLES - 20'd1;

  // Button bit positions inside the packed button vectors.
  localparam int BI_A  = 0;
  localparam int BI_B  = 1;
  localparam int BI_OP = 2;
  localparam int BI_EQ = 3;

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_CALC   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  // Magnitude of an 8-bit two's-complement value; -128 maps to 8'h80.
  function automatic logic [7:0] mag8(input logic [7:0] v);
    logic [7:0] m;
    if (v[7]) begin
      m = ~v + 8'd1;
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Magnitude of a 9-bit two's-complement value; -256 maps to 9'h100.
  function automatic logic [8:0] mag9(input logic [8:0] v);
    logic [8:0] m;
    if (v[8]) begin
      m = ~v + 9'd1;
    end else begin
      m = v;
    end
    return m;
  endfunction

  logic [3:0] w_btn_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_deb;
  logic [3:0] r_deb_d;
  logic [3:0] w_pulse;

  logic       w_act_a;
  logic       w_act_b;
  logic       w_act_op;
  logic       w_act_eq;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_op;
  logic [7:0] w_a_nxt;
  logic [7:0] w_b_nxt;
  logic       w_op_nxt;

  logic [8:0] w_ext_a;
  logic [8:0] w_ext_b;
  logic [8:0] w_res;

  assign w_btn_raw = {BTN_EQ, BTN_OP, BTN_B, BTN_A};

  // Two-flop synchroniser for all four raw buttons.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // One debouncer per button: the accepted level follows the synchronised
  // input only after it has differed for DEB_CYCLES consecutive cycles.
  for (genvar g = 0; g < 4; g++) begin : g_deb
    logic        r_deb;
    logic [19:0] r_cnt;

    // Count consecutive disagreeing cycles; any bounce restarts the count.
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_deb <= 1'b0;
        r_cnt <= 20'd0;
      end else if (r_sync2[g] == r_deb) begin
        r_cnt <= 20'd0;
      end else if (r_cnt >= DEB_LAST) begin
        r_deb <= r_sync2[g];
        r_cnt <= 20'd0;
      end else begin
        r_cnt <= r_cnt + 20'd1;
      end
    end

    assign w_deb[g] = r_deb;
  end

  // Delayed copy of the debounced levels for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_deb_d <= 4'b0000;
    end else begin
      r_deb_d <= w_deb;
    end
  end

  assign w_pulse = w_deb & ~r_deb_d;

  // Same-cycle pulses resolve as EQ > A > B > OP; losers are dropped.
  always_comb begin
    w_act_eq = w_pulse[BI_EQ];
    w_act_a  = w_pulse[BI_A]  & ~w_pulse[BI_EQ];
    w_act_b  = w_pulse[BI_B]  & ~w_pulse[BI_EQ] & ~w_pulse[BI_A];
    w_act_op = w_pulse[BI_OP] & ~w_pulse[BI_EQ] & ~w_pulse[BI_A] & ~w_pulse[BI_B];
  end

  // Sign-extended operands and the 9-bit result; the range -256..+255
  // always fits, so modulo-512 arithmetic is exact.
  always_comb begin
    w_ext_a = {r_a[7], r_a};
    w_ext_b = {r_b[7], r_b};
    if (r_op) begin
      w_res = w_ext_a - w_ext_b;
    end else begin
      w_res = w_ext_a + w_ext_b;
    end
  end

  // Next state and operand values; pulses arriving in CALC are ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    case (r_state)
      ST_ENTRY, ST_RESULT: begin
        if (w_act_eq) begin
          w_state_nxt = ST_CALC;
        end else if (w_act_a) begin
          w_a_nxt     = SW;
          w_state_nxt = ST_ENTRY;
        end else if (w_act_b) begin
          w_b_nxt     = SW;
          w_state_nxt = ST_ENTRY;
        end else if (w_act_op) begin
          w_op_nxt    = ~r_op;
          w_state_nxt = ST_ENTRY;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_CALC: begin
        w_state_nxt = ST_RESULT;
      end
      default: begin
        w_state_nxt = ST_ENTRY;
      end
    endcase
  end

  // State, operand and operation registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_ENTRY;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
    end
  end

  // Display registers, updated on the same edge as the state they reflect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      x   <= 16'h0000;
      neg <= 4'b0000;
    end else begin
      case (w_state_nxt)
        ST_ENTRY: begin
          x   <= {mag8(w_a_nxt), mag8(w_b_nxt)};
          neg <= {w_a_nxt[7], 1'b0, w_b_nxt[7], 1'b0};
        end
        ST_RESULT: begin
          if (r_state == ST_CALC) begin
            x   <= {7'b0000000, mag9(w_res)};
            neg <= {w_res[8], 3'b000};
          end else begin
            x   <= x;
            neg <= neg;
          end
        end
        ST_CALC: begin
          x   <= x;
          neg <= neg;
        end
        default: begin
          x   <= x;
          neg <= neg;
        end
      endcase
    end
  end

  assign OP_SUB = r_op;

endmodule
